// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) request encoder.
// Modes: lowest-first, highest-first, round-robin, strict one-hot.
module prio_encoder_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         onehot_err
);

  logic [W-1:0] ptr;
  logic [W-1:0] lo_idx;
  logic [W-1:0] hi_idx;
  logic [W-1:0] rr_idx;
  logic         rr_hit;
  logic         any;
  logic         multi;
  logic [W-1:0] sel_idx;
  logic [W-1:0] ptr_nxt;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    rr_idx = '0;
    rr_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (req[W'(i)]) lo_idx = W'(i);
    for (int i = 0; i < N; i++)
      if (req[W'(i)]) hi_idx = W'(i);
    // Walk upward from ptr, wrapping modulo N
    for (int k = 0; k < N; k++) begin
      if (!rr_hit && req[W'((int'(ptr) + k) % N)]) begin
        rr_hit = 1'b1;
        rr_idx = W'((int'(ptr) + k) % N);
      end
    end
  end

  assign any   = |req;
  assign multi = (req & (req - N'(1))) != '0;

  always_comb begin
    sel_idx = lo_idx;
    unique case (mode)
      2'b00:   sel_idx = lo_idx;
      2'b01:   sel_idx = hi_idx;
      2'b10:   sel_idx = rr_idx;
      default: sel_idx = lo_idx;
    endcase
  end

  assign ptr_nxt = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code       <= '0;
      grant      <= '0;
      valid      <= 1'b0;
      onehot_err <= 1'b0;
      ptr        <= '0;
    end else if (!en) begin
      grant      <= '0;
      valid      <= 1'b0;
      onehot_err <= 1'b0;
    end else if (!any) begin
      code       <= '0;
      grant      <= '0;
      valid      <= 1'b0;
      onehot_err <= 1'b0;
    end else if (mode == 2'b11 && multi) begin
      code       <= '0;
      grant      <= '0;
      valid      <= 1'b0;
      onehot_err <= 1'b1;
    end else begin
      code       <= sel_idx;
      grant      <= N'(1) << sel_idx;
      valid      <= 1'b1;
      onehot_err <= 1'b0;
      if (mode == 2'b10) ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: N=8 and N=5 instances
// checked each cycle against a behavioural model.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] req8 = '0;
  logic [4:0] req5 = '0;

  logic [2:0] code8;
  logic [7:0] grant8;
  logic       valid8;
  logic       err8;
  logic [2:0] code5;
  logic [4:0] grant5;
  logic       valid5;
  logic       err5;

  int vectors = 0;
  int errors  = 0;

  int m_code[2];
  int m_grant[2];
  int m_valid[2];
  int m_err[2];
  int m_ptr[2];

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .req(req8), .code(code8), .grant(grant8),
    .valid(valid8), .onehot_err(err8)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .req(req5), .code(code5), .grant(grant5),
    .valid(valid5), .onehot_err(err5)
  );

  task automatic chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int popcnt(int v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += (v >> i) & 1;
    return c;
  endfunction

  // Model from the behavioural rules, one instance u of width n
  task automatic step(int u, int n, bit rst, bit e, int md, int r);
    int sel;
    sel = -1;
    if (!rst) begin
      m_code[u] = 0; m_grant[u] = 0; m_valid[u] = 0;
      m_err[u] = 0; m_ptr[u] = 0;
      return;
    end
    if (!e) begin
      m_grant[u] = 0; m_valid[u] = 0; m_err[u] = 0;
      return;
    end
    if (r == 0) begin
      m_code[u] = 0; m_grant[u] = 0; m_valid[u] = 0; m_err[u] = 0;
      return;
    end
    case (md)
      0: for (int i = n - 1; i >= 0; i--) if (r[i]) sel = i;
      1: for (int i = 0; i < n; i++) if (r[i]) sel = i;
      2: for (int k = n - 1; k >= 0; k--)
           if (r[(m_ptr[u] + k) % n]) sel = (m_ptr[u] + k) % n;
      default:
        if (popcnt(r) == 1)
          for (int i = 0; i < n; i++) if (r[i]) sel = i;
    endcase
    if (sel < 0) begin
      m_code[u] = 0; m_grant[u] = 0; m_valid[u] = 0; m_err[u] = 1;
    end else begin
      m_code[u] = sel; m_grant[u] = 1 << sel;
      m_valid[u] = 1; m_err[u] = 0;
      if (md == 2) m_ptr[u] = (sel + 1) % n;
    end
  endtask

  always @(posedge clk) begin
    step(0, 8, rst_n, en, int'(mode), int'(req8));
    step(1, 5, rst_n, en, int'(mode), int'(req5));
    #1;
    chk("code8",  int'(code8),  m_code[0]);
    chk("grant8", int'(grant8), m_grant[0]);
    chk("valid8", int'(valid8), m_valid[0]);
    chk("err8",   int'(err8),   m_err[0]);
    chk("code5",  int'(code5),  m_code[1]);
    chk("grant5", int'(grant5), m_grant[1]);
    chk("valid5", int'(valid5), m_valid[1]);
    chk("err5",   int'(err5),   m_err[1]);
    if (valid8) chk("inv_grant8", int'(grant8), 1 << code8);
    if (valid5) chk("inv_grant5", int'(grant5), 1 << code5);
    if (err8) chk("inv_err8", int'(valid8), 0);
    if (err5) chk("inv_err5", int'(valid5), 0);
    chk("code5_range", int'(code5 <= 3'd4), 1);
  end

  task automatic cyc(bit r, bit e, logic [1:0] m,
                     logic [7:0] q8, logic [4:0] q5);
    @(negedge clk);
    rst_n = r; en = e; mode = m; req8 = q8; req5 = q5;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with all requests high
    cyc(0, 1, 2'b00, 8'hFF, 5'h1F);
    cyc(0, 1, 2'b00, 8'hFF, 5'h1F);
    chk("rst_code", int'(code8), 0);
    chk("rst_grant", int'(grant8), 0);
    chk("rst_valid", int'(valid8), 0);
    chk("rst_err", int'(err8), 0);
    cyc(1, 1, 2'b00, 8'h00, 5'h00);
    chk("idle_valid", int'(valid8), 0);

    cyc(1, 1, 2'b00, 8'b0110_1000, 5'h00);
    chk("lo_code", int'(code8), 3);
    chk("lo_grant", int'(grant8), 8'h08);
    chk("lo_valid", int'(valid8), 1);
    cyc(1, 1, 2'b01, 8'b0110_1000, 5'h00);
    chk("hi_code", int'(code8), 6);
    chk("hi_grant", int'(grant8), 8'h40);

    // Round-robin rotation and wrap on both widths
    cyc(1, 1, 2'b10, 8'b1000_0101, 5'b10001);
    chk("rr0", int'(code8), 0);
    chk("rr5_0", int'(code5), 0);
    cyc(1, 1, 2'b10, 8'b1000_0101, 5'b10001);
    chk("rr1", int'(code8), 2);
    chk("rr5_1", int'(code5), 4);
    cyc(1, 1, 2'b10, 8'b1000_0101, 5'b10001);
    chk("rr2", int'(code8), 7);
    chk("rr5_2", int'(code5), 0);
    cyc(1, 1, 2'b10, 8'b1000_0101, 5'h00);
    chk("rr3", int'(code8), 0);

    // ptr=1 now; pick 2 so ptr=3, then hold with en low
    cyc(1, 1, 2'b10, 8'h04, 5'h00);
    chk("rr_pre", int'(code8), 2);
    cyc(1, 0, 2'b10, 8'hFF, 5'h1F);
    cyc(1, 0, 2'b10, 8'h01, 5'h02);
    cyc(1, 0, 2'b10, 8'hF0, 5'h10);
    chk("hold_code", int'(code8), 2);
    chk("hold_valid", int'(valid8), 0);
    chk("hold_grant", int'(grant8), 0);
    cyc(1, 1, 2'b10, 8'h0C, 5'h00);
    chk("resume", int'(code8), 3);

    // Strict one-hot
    cyc(1, 1, 2'b11, 8'h20, 5'h00);
    chk("strict_code", int'(code8), 5);
    chk("strict_valid", int'(valid8), 1);
    cyc(1, 1, 2'b11, 8'h21, 5'h00);
    chk("strict_err", int'(err8), 1);
    chk("strict_nv", int'(valid8), 0);
    chk("strict_code0", int'(code8), 0);
    cyc(1, 1, 2'b11, 8'h00, 5'h00);
    chk("strict_zero", int'(err8), 0);

    // Mid-stream reset then encode from ptr=0
    cyc(0, 1, 2'b10, 8'h81, 5'h11);
    cyc(1, 1, 2'b10, 8'h81, 5'h11);
    chk("post_rst", int'(code8), 0);

    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) != 0),
          2'($urandom_range(0, 3)), 8'($urandom), 5'($urandom));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-to-log2(N) encoder with selectable arbitration mode: lowest-index priority, highest-index priority, round-robin, or strict one-hot. It generalises the combinational 8-to-3 one-hot encoder. It adds a registered output stage, a valid/error qualifier, a one-hot grant vector and a rotating priority pointer. It sits between request sources (interrupt lines, FIFO-not-empty flags, channel requests) and a consumer that needs one index per cycle.

## Interface
- N, default 8: number of request inputs; must be 2 or more, and a power of two is not required.
- W, derived localparam, = $clog2(N): code width; not overridable.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- en  input  1  sample enable; when 0, no new encode and pointer frozen
- mode  input  2  00 lowest-index first, 01 highest-index first, 10 round-robin, 11 strict one-hot
- req  input  N  request vector, bit i = request from source i
- code  output  W  encoded index of selected request (registered)
- grant  output  N  one-hot of selected request, all-zero when no selection (registered)
- valid  output  1  code/grant hold a selection from last sampled cycle
- onehot_err  output  1  strict mode only: last sampled req had more than one bit set

## Operation
- Reset (rst_n=0 at a clk edge): code=0, grant=0, valid=0, onehot_err=0, rr pointer ptr=0. Reset takes priority over en and all other inputs.
- en=0 at a clk edge:
  - valid and onehot_err are cleared and grant is cleared to 0.
  - code holds its previous value.
  - ptr holds.
- en=1 and req=0, in any mode: valid=0, grant=0, onehot_err=0, code=0, ptr holds.
- mode 00: select the lowest set bit of req.
- mode 01: select the highest set bit of req.
- mode 10, round-robin:
  - Search starts at index ptr and wraps upward modulo N; select the first set bit found.
  - After a selection of index i, ptr <= (i+1) mod N; when i=N-1, ptr wraps to 0.
  - ptr is updated only in mode 10 with en=1 and a selection made.
- mode 11, strict:
  - Exactly one bit set: code=index, grant=req, valid=1, onehot_err=0.
  - Two or more bits set: valid=0, grant=0, code=0, onehot_err=1.
- In modes 00, 01 and 10, a selection drives valid=1, onehot_err=0, grant = one-hot of the selected index, code = that index.
- A mode change takes effect on the next sampled cycle. ptr is retained across mode changes and is neither reset nor modified in modes 00, 01 or 11.
- Invariant: valid=1 implies grant == (1 << code), and onehot_err=1 implies valid=0.
- For N not a power of two, code never exceeds N-1.

## Timing
- Latency is 1 cycle: req, mode and en sampled at edge k produce code, grant, valid and onehot_err visible after edge k. There is no combinational path from inputs to outputs.
- Throughput is one encode per cycle. There is no backpressure; the consumer must capture the outputs on the cycle valid=1.
- ptr update and output update occur on the same edge. The next sampled req uses the new ptr.
- A reset asserted mid-stream clears all outputs and ptr at that edge. The first cycle with rst_n=1 and en=1 encodes normally from ptr=0.
- req changing while en=0 has no effect on outputs or ptr.

## Test plan
- Reset/idle (N=8): hold rst_n=0 for 2 cycles with req=8'hFF, en=1 -> code=0, grant=0, valid=0, onehot_err=0. Release reset with req=0 -> outputs remain 0.
- Fixed priority (N=8):
  - mode=00, req=8'b0110_1000 -> next cycle code=3, grant=8'h08, valid=1.
  - mode=01, same req -> code=6, grant=8'h40.
- Round-robin rotation and wrap (N=8, mode=10): hold req=8'b1000_0101 for 4 cycles -> codes 0, 2, 7, 0; ptr after each is 1, 3, 0, 1.
- Strict mode (N=8, mode=11):
  - req=8'h20 -> code=5, valid=1, onehot_err=0.
  - req=8'h21 -> valid=0, grant=0, code=0, onehot_err=1.
  - req=0 -> all 0.
- Enable/hold (N=8, mode=10):
  - After code=2 (ptr=3), drop en for 3 cycles while toggling req -> valid=0, code holds 2, ptr stays 3.
  - Raise en with req=8'h0C -> code=3.
- Non-power-of-two (N=5, W=3), mode=10, req=5'b10001 repeated -> codes 0, 4, 0. code never reaches 5-7, and grant width is 5.
